mac_accum: RTL

Window accumulator sitting directly downstream of the 4-bit multiply-accumulate stage. Consumes its 8-bit unsigned result stream, sums a programmable number of consecutive samples with saturation, and presents each window total on a valid/ready output port. Provides the block-sum (dot-product over a window) that the stage itself does not.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_accum_if.sv | 35 +++
 rtl/sat_add.sv | 22 ++
 rtl/mac_accum.sv | 105 ++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================
// mac_pkg : shared widths and state encoding for the MAC path
// Rev 1.0
// ============================================================
package mac_pkg;

  localparam int DATA_W    = 8;
  localparam int DEF_ACC_W = 10;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_accum_if.sv
`default_nettype none
// ============================================================
// mac_accum_if : sample input and window-total output bundle
// Rev 1.0
// ============================================================
interface mac_accum_if
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  len;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic              drop;
  logic              busy;

  modport master (
    output in_valid, in_data, len, clear, out_ready,
    input  out_valid, out_sum, out_sat, drop, busy
  );

  modport slave (
    input  in_valid, in_data, len, clear, out_ready,
    output out_valid, out_sum, out_sat, drop, busy
  );

endinterface
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================
// sat_add : unsigned saturating adder with overflow flag
// Rev 1.0
// ============================================================
module sat_add #(
  parameter int ACC_W = 10
) (
  input  wire logic [ACC_W-1:0] a,
  input  wire logic [ACC_W-1:0] b,
  output logic      [ACC_W-1:0] sum,
  output logic                  ovf
);

  logic [ACC_W:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[ACC_W];
  assign sum = ovf ? {ACC_W{1'b1}} : raw[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================
// mac_accum : saturating window accumulator with valid/ready output
// Rev 1.0
// ============================================================
module mac_accum
  import mac_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  mac_accum_if.slave bus
);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;
  logic             open_win;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (ACC_W'(bus.in_data)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sat_d    = sat_q;
    drop_d   = drop_q;
    open_win = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      drop_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: open_win = bus.in_valid;
        ACCUM: begin
          if (bus.in_valid) begin
            acc_d = add_sum;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == len_q - CNT_W'(1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // A sample arriving with the handshake starts the next window directly.
            if (bus.in_valid) open_win = 1'b1;
            else              state_d  = IDLE;
          end else if (bus.in_valid) begin
            drop_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (open_win) begin
        acc_d   = ACC_W'(bus.in_data);
        len_d   = bus.len;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = (bus.len == '0) ? HOLD : ACCUM;
      end
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_sat   = sat_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = (state_q == ACCUM);

endmodule
`default_nettype wire
